// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

  localparam int   DATA_BITS_DEFAULT = 8;
  localparam logic IDLE_LEVEL        = 1'b1;
  localparam logic START_LEVEL       = 1'b0;
  localparam logic STOP_LEVEL        = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_edge.sv
// Registers the divider's baud_clk into the clk domain and emits a one-clk tick
// per rising edge. Both flops reset high so a level already high at release is not an edge.
module uart_baud_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic baud_clk_i,
  output logic tick_o
);

  logic bq1_q;
  logic bq2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bq1_q <= 1'b1;
      bq2_q <= 1'b1;
    end else begin
      bq1_q <= baud_clk_i;
      bq2_q <= bq1_q;
    end
  end

  assign tick_o = bq1_q & ~bq2_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a tick-paced frame FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic                 txd_q, txd_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [2:0]           cnt_q, cnt_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif
  logic                 tick;
  logic                 accept;
  logic                 load;

  uart_baud_edge u_baud_edge (
    .clk_i      (clk),
    .reset_i    (reset),
    .baud_clk_i (baud_clk),
    .tick_o     (tick)
  );

  // Handshake: a word moves into hold on any clk edge where tx_valid & tx_ready.
  assign accept = tx_valid & ~hold_full_q;
  assign load   = tick & hold_full_q & ((state_q == ST_IDLE) | (state_q == ST_STOP));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      txd_q       <= IDLE_LEVEL;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_IDLE:   if (hold_full_q) state_d = ST_START;
        ST_START:  state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
        ST_DATA:   if (cnt_q == LAST_BIT) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
`else
        ST_DATA:   if (cnt_q == LAST_BIT) state_d = ST_STOP;
`endif
        ST_STOP:   state_d = hold_full_q ? ST_START : ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // txd_d is the level for the bit period that begins at the coming tick edge.
  always_comb begin
    txd_d       = txd_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      txd_d       = START_LEVEL;
      cnt_d       = 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end else if (tick) begin
      case (state_q)
        ST_START: begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = 3'd0;
        end
        ST_DATA: begin
          if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            txd_d = parity_q;
`else
            txd_d = STOP_LEVEL;
`endif
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: txd_d = STOP_LEVEL;
`endif
        ST_STOP:   txd_d = IDLE_LEVEL;
        default:   txd_d = txd_q;
      endcase
    end
  end

  assign tx_ready = ~hold_full_q;
  assign txd      = txd_q;
  assign busy     = (state_q != ST_IDLE) | hold_full_q;

endmodule
